// File: rtl/cic3_row_readout.sv
// Readout stage behind the CIC3 filter row. Once per decimation period it takes a snapshot of
// every channel word, then streams the words one channel per valid/ready beat.
module cic3_row_readout #(
    parameter int NUM_CH        = 24,
    parameter int WORD_W        = 25,
    parameter int DECIM_RATIO   = 32,
    parameter int CAPTURE_PHASE = 16,
    parameter int CH_W          = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [NUM_CH*WORD_W-1:0] filt_in,
    output logic [WORD_W-1:0]        dout,
    output logic [CH_W-1:0]          dout_ch,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     frame_start,
    output logic [7:0]               frame_cnt,
    output logic                     overrun,
    input  logic                     overrun_clr
);
    localparam int DCNT_W = (DECIM_RATIO > 1) ? $clog2(DECIM_RATIO) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                        state_q, state_d;
    logic [DCNT_W-1:0]             dcnt_q, dcnt_d;
    logic [NUM_CH-1:0][WORD_W-1:0] snap_q, snap_d;
    logic [CH_W-1:0]               ch_idx_q, ch_idx_d;
    logic [WORD_W-1:0]             dout_q, dout_d;
    logic                          dout_valid_q, dout_valid_d;
    logic                          frame_start_q, frame_start_d;
    logic [7:0]                    frame_cnt_q, frame_cnt_d;
    logic                          overrun_q, overrun_d;

    logic capture_evt;
    logic accept;
    logic last_beat;
    logic load;

    assign capture_evt = enable && (dcnt_q == DCNT_W'(CAPTURE_PHASE));
    assign accept      = dout_valid_q && dout_ready;
    assign last_beat   = (ch_idx_q == CH_W'(NUM_CH - 1));
    // A capture coinciding with the final accepted beat chains straight into the next frame.
    assign load        = capture_evt &&
                         ((state_q == IDLE) || (accept && last_beat));

    always_comb begin
        dcnt_d        = '0;
        state_d       = state_q;
        snap_d        = snap_q;
        ch_idx_d      = ch_idx_q;
        dout_d        = dout_q;
        dout_valid_d  = dout_valid_q;
        frame_start_d = frame_start_q;
        frame_cnt_d   = frame_cnt_q;
        overrun_d     = overrun_q && !overrun_clr;

        if (enable && (dcnt_q != DCNT_W'(DECIM_RATIO - 1))) begin
            dcnt_d = dcnt_q + DCNT_W'(1);
        end

        if (load) begin
            state_d       = STREAM;
            snap_d        = filt_in;
            ch_idx_d      = '0;
            dout_d        = filt_in[WORD_W-1:0];
            dout_valid_d  = 1'b1;
            frame_start_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + 8'd1;
        end else if (state_q == STREAM) begin
            if (capture_evt) begin
                overrun_d = 1'b1;
            end
            if (accept && last_beat) begin
                state_d       = IDLE;
                dout_valid_d  = 1'b0;
                frame_start_d = 1'b0;
            end else if (accept) begin
                ch_idx_d      = ch_idx_q + CH_W'(1);
                dout_d        = snap_q[ch_idx_q + CH_W'(1)];
                frame_start_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            dcnt_q        <= '0;
            snap_q        <= '0;
            ch_idx_q      <= '0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            dcnt_q        <= dcnt_d;
            snap_q        <= snap_d;
            ch_idx_q      <= ch_idx_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            overrun_q     <= overrun_d;
        end
    end

    assign dout        = dout_q;
    assign dout_ch     = ch_idx_q;
    assign dout_valid  = dout_valid_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_cic3_row_readout.sv
// Directed bench for cic3_row_readout: a scoreboard queue holds the expected beats of every
// frame the bench expects to be captured, and is popped on each accepted beat.
module tb_cic3_row_readout;
    localparam int NUM_CH = 24;
    localparam int WORD_W = 25;
    localparam int CH_W   = 5;
    localparam logic [WORD_W-1:0] BASE0 = 25'h0;
    localparam logic [WORD_W-1:0] BASE1 = 25'h100000;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [CH_W-1:0]   ch;
        logic              fs;
    } beat_t;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     enable;
    logic                     dout_ready;
    logic                     overrun_clr;
    logic [NUM_CH*WORD_W-1:0] filt_in;
    logic [WORD_W-1:0]        dout;
    logic [CH_W-1:0]          dout_ch;
    logic                     dout_valid;
    logic                     frame_start;
    logic [7:0]               frame_cnt;
    logic                     overrun;

    logic                     en_b;
    logic                     ready_b;
    logic                     clr_b;
    logic [WORD_W-1:0]        dout_b;
    logic [CH_W-1:0]          dout_ch_b;
    logic                     dout_valid_b;
    logic                     frame_start_b;
    logic [7:0]               frame_cnt_b;
    logic                     overrun_b;

    beat_t sb[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;

    always #5 clk = ~clk;

    cic3_row_readout #(.DECIM_RATIO(32), .CAPTURE_PHASE(16)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .filt_in(filt_in),
        .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .frame_start(frame_start), .frame_cnt(frame_cnt), .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    cic3_row_readout #(.DECIM_RATIO(24), .CAPTURE_PHASE(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(en_b), .filt_in(filt_in),
        .dout(dout_b), .dout_ch(dout_ch_b), .dout_valid(dout_valid_b), .dout_ready(ready_b),
        .frame_start(frame_start_b), .frame_cnt(frame_cnt_b), .overrun(overrun_b),
        .overrun_clr(clr_b)
    );

    function automatic logic [WORD_W-1:0] word_of(input logic [WORD_W-1:0] base, input int k);
        return base + WORD_W'(k * 32'h1001);
    endfunction

    function automatic logic [NUM_CH*WORD_W-1:0] make_row(input logic [WORD_W-1:0] base);
        logic [NUM_CH*WORD_W-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_CH; k++) r[k*WORD_W +: WORD_W] = word_of(base, k);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [WORD_W-1:0] base);
        beat_t b;
        for (int k = 0; k < NUM_CH; k++) begin
            b.data = word_of(base, k);
            b.ch   = CH_W'(k);
            b.fs   = (k == 0);
            sb.push_back(b);
        end
    endtask

    // One clock step: apply inputs for the coming edge, then score any beat it will accept.
    task automatic applyStimulus(input logic rdy, input logic en, input logic clr);
        beat_t e;
        @(negedge clk);
        cyc++;
        dout_ready  = rdy;
        enable      = en;
        overrun_clr = clr;
        if (dout_valid && rdy) begin
            checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("beat_data", 32'(dout), 32'(e.data));
                checkOutput("beat_ch", 32'(dout_ch), 32'(e.ch));
                checkOutput("beat_fs", 32'(frame_start), 32'(e.fs));
            end
        end
    endtask

    task automatic run_to(input int target, input logic rdy, input logic en);
        while (cyc < target) applyStimulus(rdy, en, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_dout"}, 32'(dout), 32'd0);
        checkOutput({tag, "_ch"}, 32'(dout_ch), 32'd0);
        checkOutput({tag, "_valid"}, 32'(dout_valid), 32'd0);
        checkOutput({tag, "_fs"}, 32'(frame_start), 32'd0);
        checkOutput({tag, "_cnt"}, 32'(frame_cnt), 32'd0);
        checkOutput({tag, "_ovr"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        logic stray;
        int   s0;
        int   b0;
        int   idx;
        reset_n = 1'b0; enable = 1'b0; dout_ready = 1'b0; overrun_clr = 1'b0;
        en_b = 1'b0; ready_b = 1'b1; clr_b = 1'b0;
        filt_in = make_row(BASE0);
        #12;
        check_all_zero("rst");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("idle_valid", 32'(dout_valid), 32'd0);

        // Frame 1: capture at dcnt 16, ch0 visible 17 steps after enable.
        cyc = -1;
        push_frame(BASE0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        run_to(16, 1'b1, 1'b1);
        checkOutput("lat_early", 32'(dout_valid), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("lat_ch0", 32'(dout_valid), 32'd1);
        run_to(40, 1'b1, 1'b1);
        checkOutput("f1_last_ch", 32'(dout_ch), 32'd23);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("f1_idle", 32'(dout_valid), 32'd0);
        checkOutput("f1_cnt", 32'(frame_cnt), 32'd1);
        checkOutput("f1_drained", 32'(sb.size()), 32'd0);

        // Frame 2: backpressure while ch5 is presented.
        push_frame(BASE0);
        run_to(53, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("bp_ch5_data", 32'(dout), 32'h5005);
        checkOutput("bp_ch5_ch", 32'(dout_ch), 32'd5);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("bp_hold_data", 32'(dout), 32'h5005);
        checkOutput("bp_hold_ch", 32'(dout_ch), 32'd5);
        checkOutput("bp_hold_valid", 32'(dout_valid), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("bp_ch6", 32'(dout_ch), 32'd6);
        run_to(76, 1'b1, 1'b1);
        checkOutput("f2_idle", 32'(dout_valid), 32'd0);
        checkOutput("f2_cnt", 32'(frame_cnt), 32'd2);

        // Frame 3: stall for a whole period so the capture at edge 112 is dropped.
        push_frame(BASE0);
        run_to(80, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        filt_in = make_row(BASE1);
        run_to(112, 1'b0, 1'b1);
        checkOutput("ovr_before", 32'(overrun), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("ovr_set", 32'(overrun), 32'd1);
        checkOutput("ovr_cnt", 32'(frame_cnt), 32'd3);
        checkOutput("ovr_ch", 32'(dout_ch), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("ovr_clr", 32'(overrun), 32'd0);
        run_to(138, 1'b1, 1'b1);
        checkOutput("f3_idle", 32'(dout_valid), 32'd0);
        checkOutput("f3_drained", 32'(sb.size()), 32'd0);

        // Frame 4: drop at edge 176 coincides with overrun_clr; set must win.
        push_frame(BASE1);
        run_to(144, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        run_to(175, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("ovr_pre_drop", 32'(overrun), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("ovr_clr_drop", 32'(overrun), 32'd1);
        checkOutput("f4_cnt", 32'(frame_cnt), 32'd4);
        run_to(202, 1'b1, 1'b1);
        checkOutput("f4_idle", 32'(dout_valid), 32'd0);
        checkOutput("f4_drained", 32'(sb.size()), 32'd0);

        // Frame 5: enable drops while ch10 is presented; frame still completes.
        filt_in = make_row(BASE0);
        push_frame(BASE0);
        run_to(218, 1'b1, 1'b1);
        checkOutput("dis_ch10", 32'(dout_ch), 32'd9);
        run_to(232, 1'b1, 1'b0);
        checkOutput("dis_last", 32'(dout_ch), 32'd23);
        checkOutput("dis_last_valid", 32'(dout_valid), 32'd1);
        stray = 1'b0;
        repeat (100) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            if (dout_valid) stray = 1'b1;
        end
        checkOutput("dis_no_frame", 32'(stray), 32'd0);
        checkOutput("dis_cnt", 32'(frame_cnt), 32'd5);
        s0 = cyc + 1;
        push_frame(BASE0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        run_to(s0 + 16, 1'b1, 1'b1);
        checkOutput("reen_early", 32'(dout_valid), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("reen_ch0", 32'(dout_valid), 32'd1);
        checkOutput("reen_cnt", 32'(frame_cnt), 32'd6);

        // Asynchronous reset in the middle of a frame.
        run_to(s0 + 20, 1'b1, 1'b1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_rst");
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        push_frame(BASE0);
        run_to(16, 1'b1, 1'b1);
        checkOutput("post_rst_idle", 32'(dout_valid), 32'd0);
        checkOutput("post_rst_cnt", 32'(frame_cnt), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("post_rst_ch0", 32'(dout_valid), 32'd1);
        checkOutput("post_rst_cnt1", 32'(frame_cnt), 32'd1);
        run_to(41, 1'b1, 1'b1);
        checkOutput("post_rst_drained", 32'(sb.size()), 32'd0);

        // DECIM_RATIO=24 instance: frames run back to back with no bubble.
        en_b = 1'b1;
        b0 = cyc;
        for (int j = 1; j <= 17 + 72; j++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            if (j >= 17) begin
                idx = (j - 17) % NUM_CH;
                checkOutput("b2b_valid", 32'(dout_valid_b), 32'd1);
                checkOutput("b2b_ch", 32'(dout_ch_b), 32'(idx));
                checkOutput("b2b_data", 32'(dout_b), 32'(word_of(BASE0, idx)));
                checkOutput("b2b_fs", 32'(frame_start_b), 32'(idx == 0));
                checkOutput("b2b_ovr", 32'(overrun_b), 32'd0);
            end
        end
        checkOutput("b2b_cnt", 32'(frame_cnt_b), 32'd4);
        checkOutput("b2b_start", 32'(cyc - b0), 32'd89);
        checkOutput("final_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
